// File: rtl/adder_seq_chunked.sv
// Multi-cycle WIDTH-bit add/subtract unit that handles CHUNK bits per clock and carries between chunks in a register.
// Optional signed-overflow output is enabled with the ADDER_SEQ_OVF_EN macro.
module adder_seq_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a, op_b, res, res_next;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [CHUNK:0]   chunk_full;
  logic             accept, last;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IDXW'(NCH - 1));

  // Operands shift right so the active chunk always sits in the low CHUNK bits.
  always_comb begin
    chunk_full = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    res_next   = res >> CHUNK;
    res_next[WIDTH-1 -: CHUNK] = chunk_full[CHUNK-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is a + ~b + ~borrow, so the carry register starts inverted.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      idx   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> CHUNK;
      op_b  <= op_b >> CHUNK;
      carry <= chunk_full[CHUNK];
      res   <= res_next;
      idx   <= idx + IDXW'(1);
      if (last) begin
        sum  <= res_next;
        cout <= chunk_full[CHUNK];
`ifdef ADDER_SEQ_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        ovf  <= op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_full[CHUNK-1] ^ chunk_full[CHUNK];
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked: a 16/4 instance for most tests and a 16/16 instance for single-cycle mode.
module tb_adder_seq_chunked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, start16 = 1'b0;
  logic        sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy4, done4, cout4, busy16, done16, cout16;
  logic [15:0] sum4, sum16;
`ifdef ADDER_SEQ_OVF_EN
  logic        ovf4, ovf16;
`endif
  logic        sel = 1'b0;
  logic        busy_m, done_m, cout_m;
  logic [15:0] sum_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_seq_chunked #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef ADDER_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  adder_seq_chunked #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef ADDER_SEQ_OVF_EN
    , .ovf(ovf16)
`endif
  );

  assign busy_m = sel ? busy16 : busy4;
  assign done_m = sel ? done16 : done4;
  assign sum_m  = sel ? sum16  : sum4;
  assign cout_m = sel ? cout16 : cout4;

  typedef struct {
    string       name;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one operation and leaves the bench at the negedge right after the accept edge.
  task automatic apply_stimulus(input logic s, input logic [15:0] va, input logic [15:0] vb, input logic c);
    @(negedge clk);
    sub = s; a = va; b = vb; cin = c;
    if (sel) start16 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
  endtask

  // Counts busy cycles until done, flagging any gap in busy; bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(input string name, output int cycles);
    bit busy_ok = 1'b1;
    cycles = 0;
    while (!done_m && cycles < 20) begin
      if (!busy_m) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check_output({name, " done seen"}, 32'(done_m), 32'd1);
    check_output({name, " busy held"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic check_result(input vec_t v, input int exp_cycles);
    int cycles;
    apply_stimulus(v.sub, v.a, v.b, v.cin);
    wait_done(v.name, cycles);
    check_output({v.name, " latency"}, 32'(cycles), 32'(exp_cycles));
    check_output({v.name, " sum"}, 32'(sum_m), 32'(v.exp_sum));
    check_output({v.name, " cout"}, 32'(cout_m), 32'(v.exp_cout));
`ifdef ADDER_SEQ_OVF_EN
    check_output({v.name, " ovf"}, 32'(sel ? ovf16 : ovf4), 32'(v.exp_ovf));
`endif
    @(negedge clk);
    check_output({v.name, " done pulse"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int extra;

    vecs[0] = '{"add wrap",    1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{"sub ovf",     1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[2] = '{"sub borrow",  1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[3] = '{"add cin",     1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    vecs[4] = '{"add pos ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{"sub plain",   1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{"add all one", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{"sub zero b1", 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("reset busy", 32'(busy4), 32'd0);
    check_output("reset done", 32'(done4), 32'd0);
    check_output("reset sum",  32'(sum4),  32'd0);
    check_output("reset cout", 32'(cout4), 32'd0);

    sel = 1'b0;
    for (int i = 0; i < 8; i++) check_result(vecs[i], 4);

    // Start pulsed during RUN must be ignored, with operands left untouched.
    apply_stimulus(1'b0, 16'h0001, 16'h0001, 1'b0);
    a = 16'h1234; b = 16'h1111; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done("busy guard", cycles);
    check_output("busy guard sum", 32'(sum4), 32'h0002);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) extra++;
    end
    check_output("busy guard extra done", 32'(extra), 32'd0);

    // Start held high straight through DONE chains a second operation.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 16'h0005; b = 16'h0006; start4 = 1'b1;
    @(negedge clk);
    a = 16'h0100; b = 16'h0200;
    wait_done("b2b first", cycles);
    check_output("b2b first sum", 32'(sum4), 32'h000B);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 2) check_output("b2b sum held", 32'(sum4), 32'h000B);
    end while (!done4 && cycles < 20);
    start4 = 1'b0;
    check_output("b2b spacing", 32'(cycles), 32'd5);
    check_output("b2b second sum", 32'(sum4), 32'h0300);

    // Reset on the second RUN cycle aborts with no done afterwards.
    apply_stimulus(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort busy", 32'(busy4), 32'd0);
    check_output("abort done", 32'(done4), 32'd0);
    check_output("abort sum",  32'(sum4),  32'd0);
    check_output("abort cout", 32'(cout4), 32'd0);
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) extra++;
    end
    check_output("abort no done", 32'(extra), 32'd0);

    sel = 1'b1;
    check_result(vecs[0], 1);
    check_result(vecs[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
